// File: rtl/nx_fifo_rd_stream.sv
// nx_fifo_rd_stream
// Read-side adapter for a fixed-latency FIFO (empty/ren/rdata) that presents a
// valid/ready stream. Reads are issued only against free skid-buffer credit, so
// the buffer can never overflow and the stream runs at one word per cycle even
// across back-pressure. Each word carries its uncorrectable-error flag.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   fifo_empty        FIFO empty flag (registered in the FIFO)
//   fifo_ren          FIFO read strobe (combinational)
//   fifo_rdata/rerr   FIFO read word and its error flag, RD_LAT cycles after ren
//   clear             synchronous flush, shared with the FIFO's clear
//   out_valid/ready   stream handshake
//   out_data/out_err  stream word and its error flag
//   buf_level         occupied skid entries
//   err_cnt           saturating count of errored words accepted downstream
//   idle              registered: nothing in flight, buffer empty, FIFO empty
module nx_fifo_rd_stream #(
  parameter int RD_LAT = 1,
  parameter int DW     = 71
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  output logic          fifo_ren,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_rerr,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_err,
  output logic [1:0]    buf_level,
  output logic [15:0]   err_cnt,
  output logic          idle
);

  localparam int             BUF_DEPTH = RD_LAT + 1;
  localparam int             PW        = (BUF_DEPTH > 2) ? 2 : 1;
  localparam logic [PW-1:0]  LAST_PTR  = PW'(BUF_DEPTH - 1);
  localparam logic [2:0]     DEPTH3    = 3'(BUF_DEPTH);

  // tag_reg[i] set means a read was issued i+1 cycles ago; the top stage
  // marks the cycle in which fifo_rdata/fifo_rerr belong to that read.
  logic [RD_LAT-1:0]  tag_reg;
  logic [RD_LAT-1:0]  tag_next;
  logic [DW:0]        mem_reg [BUF_DEPTH];
  logic [PW-1:0]      wr_ptr_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic [1:0]         level_reg;
  logic [1:0]         level_next;
  logic [15:0]        err_cnt_reg;
  logic               idle_reg;

  logic               pop;
  logic               wr_en;
  logic [2:0]         inflight;
  logic [2:0]         credit_used;
  logic [BUF_DEPTH-1:0] ent_we;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (level_reg != 2'd0);
  assign pop       = out_valid & out_ready;
  // Data returning during clear is dropped along with everything else.
  assign wr_en     = tag_reg[RD_LAT-1] & ~clear;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {2'b00, tag_reg[i]};
    end
  end

  // A pop this cycle frees an entry in time for a read issued now, which is
  // what keeps a full-rate stream going without bubbles.
  assign credit_used = inflight + {1'b0, level_reg} - {2'b00, pop};
  assign fifo_ren    = ~fifo_empty & ~clear & (credit_used < DEPTH3);

  always_comb begin
    tag_next    = '0;
    tag_next[0] = fifo_ren;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_next[i] = tag_reg[i-1];
    end
  end

  always_comb begin
    level_next = level_reg;
    if (wr_en && !pop) begin
      level_next = level_reg + 2'd1;
    end else if (!wr_en && pop) begin
      level_next = level_reg - 2'd1;
    end
  end

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_we
    assign ent_we[gi] = wr_en && (wr_ptr_reg == PW'(gi));
  end

  // Storage is reset so the head (and thus out_data/out_err) reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (ent_we[i]) begin
          mem_reg[i] <= {fifo_rerr, fifo_rdata};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_reg     <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= 2'd0;
      err_cnt_reg <= 16'd0;
      idle_reg    <= 1'b1;
    end else begin
      tag_reg <= clear ? '0 : tag_next;
      if (clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= 2'd0;
      end else begin
        if (wr_en) begin
          wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
          rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        end
        level_reg <= level_next;
      end
      // A pop in the clear cycle is a real transfer, so it still counts.
      if (pop && out_err && (err_cnt_reg != 16'hFFFF)) begin
        err_cnt_reg <= err_cnt_reg + 16'd1;
      end
      idle_reg <= (tag_reg == '0) && (level_reg == 2'd0) && fifo_empty;
    end
  end

  assign out_data  = mem_reg[rd_ptr_reg][DW-1:0];
  assign out_err   = mem_reg[rd_ptr_reg][DW];
  assign buf_level = level_reg;
  assign err_cnt   = err_cnt_reg;
  assign idle      = idle_reg;

endmodule
